// File: rtl/ntt_ctrl_if.sv
// Control bundle between the NTT sequencer and the coefficient RAM / butterfly datapath.
// The sequencer is the master; the RAM-side logic (or a bench) is the slave.
interface ntt_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic       we_a;
    logic       we_b;
    logic [6:0] zeta_idx;
    logic       bf_in_valid;
    logic [2:0] layer;

    modport master (
        input  start,
        output busy, done, addr_a, addr_b, we_a, we_b, zeta_idx, bf_in_valid, layer
    );

    modport slave (
        output start,
        input  busy, done, addr_a, addr_b, we_a, we_b, zeta_idx, bf_in_valid, layer
    );
endinterface

// File: rtl/ntt_ctrl.sv
// Forward Cooley-Tukey NTT sequencer: issues 7 layers x 128 butterfly reads on even
// offsets and replays them as writes BF_LAT+1 cycles later on the odd offsets.
module ntt_ctrl #(
    parameter int BF_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    ntt_ctrl_if.master ctl
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int DL_DEPTH = BF_LAT + 1;

    state_t     state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [6:0] rd_num_q, rd_num_d;
    logic [7:0] j_q, j_d, j_inc;
    logic [6:0] k_q, k_d;
    logic [7:0] len_q, len_d;
    logic       issue;
    logic       wr_issue;
    logic       dl_any;
    logic       last_wr;

    // Read-address delay line; dl_*[n] holds the read issued n cycles ago.
    logic       dl_v [DL_DEPTH];
    logic [7:0] dl_a [DL_DEPTH];
    logic [7:0] dl_b [DL_DEPTH];

    logic       we_q, busy_q, done_q, bf_q;
    logic [7:0] addr_a_q, addr_b_q;

    assign len_q    = 8'd128 >> layer_q;
    assign len_d    = 8'd128 >> layer_d;
    assign wr_issue = dl_v[BF_LAT];

    always_comb begin
        dl_any = 1'b0;
        for (int n = 0; n < DL_DEPTH; n++) dl_any = dl_any | dl_v[n];
    end

    // The layer's final write is on the bus and nothing is left in flight behind it.
    assign last_wr = (state_q == DRAIN) && we_q && !dl_any;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ctl.start) state_d = RUN;
            RUN:     if (dl_v[0] && rd_num_q == 7'd127) state_d = DRAIN;
            DRAIN:   if (last_wr) state_d = (layer_q == 3'd6) ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        issue    = 1'b0;
        layer_d  = layer_q;
        rd_num_d = rd_num_q;
        j_d      = j_q;
        k_d      = k_q;
        j_inc    = j_q + 8'd1;
        case (state_q)
            IDLE: begin
                if (ctl.start) begin
                    issue    = 1'b1;
                    layer_d  = 3'd0;
                    rd_num_d = 7'd0;
                    j_d      = 8'd0;
                    k_d      = 7'd1;
                end
            end
            RUN: begin
                if (!dl_v[0]) begin
                    issue    = 1'b1;
                    rd_num_d = rd_num_q + 7'd1;
                    // Crossing into the len bit means the group ended: skip the bottom half.
                    if ((j_inc & len_q) != 8'd0) begin
                        j_d = j_inc + len_q;
                        k_d = k_q + 7'd1;
                    end else begin
                        j_d = j_inc;
                    end
                end
            end
            DRAIN: begin
                if (last_wr && layer_q != 3'd6) begin
                    issue    = 1'b1;
                    layer_d  = layer_q + 3'd1;
                    rd_num_d = 7'd0;
                    j_d      = 8'd0;
                    k_d      = k_q + 7'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            state_q  <= IDLE;
            layer_q  <= 3'd0;
            rd_num_q <= 7'd0;
            j_q      <= 8'd0;
            k_q      <= 7'd0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bf_q     <= 1'b0;
            addr_a_q <= 8'd0;
            addr_b_q <= 8'd0;
            for (int n = 0; n < DL_DEPTH; n++) dl_v[n] <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            rd_num_q <= rd_num_d;
            j_q      <= j_d;
            k_q      <= k_d;
            we_q     <= wr_issue;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
            bf_q     <= dl_v[0];
            if (issue) begin
                addr_a_q <= j_d;
                addr_b_q <= j_d + len_d;
            end else if (wr_issue) begin
                addr_a_q <= dl_a[BF_LAT];
                addr_b_q <= dl_b[BF_LAT];
            end
            dl_v[0] <= issue;
            for (int n = 1; n < DL_DEPTH; n++) dl_v[n] <= dl_v[n-1];
        end
    end

    // NOTE: the delay-line addresses carry no reset; they are qualified by dl_v, which is reset.
    always_ff @(posedge clk) begin
        dl_a[0] <= j_d;
        dl_b[0] <= j_d + len_d;
        for (int n = 1; n < DL_DEPTH; n++) begin
            dl_a[n] <= dl_a[n-1];
            dl_b[n] <= dl_b[n-1];
        end
    end

    assign ctl.busy        = busy_q;
    assign ctl.done        = done_q;
    assign ctl.addr_a      = addr_a_q;
    assign ctl.addr_b      = addr_b_q;
    assign ctl.we_a        = we_q;
    assign ctl.we_b        = we_q;
    assign ctl.zeta_idx    = k_q;
    assign ctl.bf_in_valid = bf_q;
    assign ctl.layer       = layer_q;
endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: a RAM + butterfly + zeta ROM model follows the controller's strobes,
// and the resulting RAM is compared with a loop-based software Kyber NTT.
module tb_ntt_ctrl;
    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_ctrl_if b4 ();
    ntt_ctrl_if b2 ();

    ntt_ctrl #(.BF_LAT(4)) u_dut4 (.clk(clk), .rst(rst), .ctl(b4));
    ntt_ctrl #(.BF_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .ctl(b2));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         a;
        int         b;
        logic [7:0] ia;
        logic [7:0] ib;
        int         stamp;
    } bfly_t;

    int    zetas    [128];
    int    mem      [256];
    int    ref_poly [256];
    bfly_t pend     [$];
    bit    sel = 1'b0;   // 0 selects the BF_LAT=4 instance, 1 the BF_LAT=2 instance
    int    cyc_abs = 0;
    int    wr_count = 0;

    logic       m_busy, m_done, m_we_a, m_we_b, m_bf;
    logic [7:0] m_addr_a, m_addr_b;
    logic [6:0] m_zeta;
    logic [2:0] m_layer;

    assign m_busy   = sel ? b2.busy        : b4.busy;
    assign m_done   = sel ? b2.done        : b4.done;
    assign m_we_a   = sel ? b2.we_a        : b4.we_a;
    assign m_we_b   = sel ? b2.we_b        : b4.we_b;
    assign m_bf     = sel ? b2.bf_in_valid : b4.bf_in_valid;
    assign m_addr_a = sel ? b2.addr_a      : b4.addr_a;
    assign m_addr_b = sel ? b2.addr_b      : b4.addr_b;
    assign m_zeta   = sel ? b2.zeta_idx    : b4.zeta_idx;
    assign m_layer  = sel ? b2.layer       : b4.layer;

    function automatic int brv7(input int x);
        int r = 0;
        for (int i = 0; i < 7; i++) if (((x >> i) & 1) != 0) r = r | (1 << (6 - i));
        return r;
    endfunction

    function automatic int zeta_of(input int k);
        int r = 1;
        for (int e = 0; e < brv7(k); e++) r = (r * 17) % Q;
        return r;
    endfunction

    // RAM + butterfly model, evaluated on the falling edge with that cycle's outputs.
    logic       we_d1 = 1'b0;
    logic [7:0] ra_d1 = 8'd0, rb_d1 = 8'd0;
    logic [6:0] z_d1  = 7'd0;
    always @(negedge clk) begin
        int    t, lat;
        bfly_t e;
        cyc_abs++;
        lat = sel ? 2 : 4;
        if (rst === 1'b1) begin
            pend.delete();
            we_d1 = 1'b0;
        end else begin
            if (m_bf === 1'b1) begin
                checks++;
                if (we_d1 !== 1'b0) begin
                    failures++;
                    $display("FAIL rd_wr_overlap cycle=%0d we_on_read_cycle=%b required=0", cyc_abs, we_d1);
                end
                t       = (zetas[z_d1] * mem[rb_d1]) % Q;
                e.a     = (mem[ra_d1] + t) % Q;
                e.b     = (mem[ra_d1] - t + Q) % Q;
                e.ia    = ra_d1;
                e.ib    = rb_d1;
                e.stamp = cyc_abs;
                pend.push_back(e);
            end
            if (m_we_a === 1'b1 || m_we_b === 1'b1) begin
                checks++;
                if (pend.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_write cycle=%0d addr=%0d/%0d required=no write", cyc_abs, m_addr_a, m_addr_b);
                end else begin
                    e = pend.pop_front();
                    if (m_we_a !== 1'b1 || m_we_b !== 1'b1 || m_addr_a !== e.ia || m_addr_b !== e.ib
                        || cyc_abs - e.stamp != lat) begin
                        failures++;
                        $display("FAIL write_slot cycle=%0d we=%b%b addr=%0d/%0d lat=%0d required we=11 addr=%0d/%0d lat=%0d",
                                 cyc_abs, m_we_a, m_we_b, m_addr_a, m_addr_b, cyc_abs - e.stamp, e.ia, e.ib, lat);
                    end
                    mem[e.ia] = e.a;
                    mem[e.ib] = e.b;
                    wr_count++;
                end
            end
            we_d1 = m_we_a | m_we_b;
        end
        ra_d1 = m_addr_a;
        rb_d1 = m_addr_b;
        z_d1  = m_zeta;
    end

    task automatic ntt_ref();
        int k, t, z;
        k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                z = zetas[k];
                k++;
                for (int j = st; j < st + len; j++) begin
                    t               = (z * ref_poly[j + len]) % Q;
                    ref_poly[j+len] = (ref_poly[j] - t + Q) % Q;
                    ref_poly[j]     = (ref_poly[j] + t) % Q;
                end
            end
        end
    endtask

    task automatic load_poly();
        for (int i = 0; i < 256; i++) begin
            mem[i]      = $urandom_range(0, Q - 1);
            ref_poly[i] = mem[i];
        end
        ntt_ref();
    endtask

    task automatic test_reset();
        logic [30:0] o4, o2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            o4 = {b4.busy, b4.done, b4.we_a, b4.we_b, b4.addr_a, b4.addr_b, b4.zeta_idx, b4.bf_in_valid, b4.layer};
            o2 = {b2.busy, b2.done, b2.we_a, b2.we_b, b2.addr_a, b2.addr_b, b2.zeta_idx, b2.bf_in_valid, b2.layer};
            checks++;
            if (o4 !== 31'd0 || o2 !== 31'd0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d outputs lat4=%h lat2=%h required=0", c, o4, o2);
            end
        end
    endtask

    // Full transform on the selected instance: schedule points, done/busy timing, RAM result.
    task automatic do_full(input bit use2);
        int          lat, p, last, done_cyc, done_cnt, busy_bad, bad, first_bad;
        logic [26:0] obs, exp_v;
        lat  = use2 ? 2 : 4;
        p    = 256 + lat;
        last = 7 * p + 4;
        sel  = use2;
        load_poly();
        wr_count = 0;
        @(negedge clk);
        if (use2) b2.start = 1'b1; else b4.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        b4.start = 1'b0;
        done_cyc = -1;
        done_cnt = 0;
        busy_bad = 0;
        for (int cyc = 1; cyc <= last; cyc++) begin
            if (m_busy !== ((cyc <= 7 * p + 1) ? 1'b1 : 1'b0)) busy_bad++;
            if (m_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            obs = {m_layer, m_addr_a, m_addr_b, m_zeta, m_we_a};
            if (cyc == 1 || cyc == 3 || cyc == p + 1 || cyc == p + 129) begin
                if (cyc == 1)          exp_v = {3'd0, 8'd0,   8'd128, 7'd1, 1'b0};
                else if (cyc == 3)     exp_v = {3'd0, 8'd1,   8'd129, 7'd1, 1'b0};
                else if (cyc == p + 1) exp_v = {3'd1, 8'd0,   8'd64,  7'd2, 1'b0};
                else                   exp_v = {3'd1, 8'd128, 8'd192, 7'd3, 1'b0};
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL read_slot lat=%0d cycle=%0d layer/a/b/zeta/we got=%0d/%0d/%0d/%0d/%b required=%0d/%0d/%0d/%0d/%b",
                             lat, cyc, obs[26:24], obs[23:16], obs[15:8], obs[7:1], obs[0],
                             exp_v[26:24], exp_v[23:16], exp_v[15:8], exp_v[7:1], exp_v[0]);
                end
            end
            if (cyc == 2) begin
                checks++;
                if ({m_bf, m_we_a} !== 2'b10) begin
                    failures++;
                    $display("FAIL bf_in_valid lat=%0d cycle=2 bf/we got=%b%b required=10", lat, m_bf, m_we_a);
                end
            end
            if (cyc == 2 + lat || cyc == p) begin
                exp_v = (cyc == p) ? {3'd0, 8'd127, 8'd255, 7'd0, 1'b1} : {3'd0, 8'd0, 8'd128, 7'd0, 1'b1};
                checks++;
                if ({m_we_a, m_we_b, m_addr_a, m_addr_b} !== {1'b1, 1'b1, exp_v[23:8]}) begin
                    failures++;
                    $display("FAIL write_point lat=%0d cycle=%0d we=%b%b addr=%0d/%0d required we=11 addr=%0d/%0d",
                             lat, cyc, m_we_a, m_we_b, m_addr_a, m_addr_b, exp_v[23:16], exp_v[15:8]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (done_cyc != 7 * p + 1 || done_cnt != 1) begin
            failures++;
            $display("FAIL done_timing lat=%0d done_cycle=%0d pulses=%0d required cycle=%0d pulses=1",
                     lat, done_cyc, done_cnt, 7 * p + 1);
        end
        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL busy_window lat=%0d bad_cycles=%0d required=0", lat, busy_bad);
        end
        checks++;
        if (wr_count != 896 || pend.size() != 0) begin
            failures++;
            $display("FAIL write_count lat=%0d writes=%0d pending=%0d required writes=896 pending=0",
                     lat, wr_count, pend.size());
        end
        bad       = 0;
        first_bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] != ref_poly[i]) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ram_vs_ref_ntt lat=%0d mismatches=%0d idx=%0d got=%0d required=%0d",
                     lat, bad, first_bad, mem[first_bad], ref_poly[first_bad]);
        end
    endtask

    task automatic test_abort();
        logic [30:0] o;
        sel = 1'b0;
        load_poly();
        @(negedge clk);
        b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        for (int cyc = 1; cyc <= 851; cyc++) begin
            if (cyc == 100) b4.start = 1'b1;
            if (cyc == 101) begin
                b4.start = 1'b0;
                checks++;
                if ({b4.busy, b4.addr_a, b4.addr_b, b4.zeta_idx} !== {1'b1, 8'd50, 8'd178, 7'd1}) begin
                    failures++;
                    $display("FAIL start_ignored cycle=101 busy=%b addr=%0d/%0d zeta=%0d required busy=1 addr=50/178 zeta=1",
                             b4.busy, b4.addr_a, b4.addr_b, b4.zeta_idx);
                end
            end
            if (cyc == 850) begin
                checks++;
                if (b4.layer !== 3'd3) begin
                    failures++;
                    $display("FAIL abort_layer cycle=850 layer=%0d required=3", b4.layer);
                end
                rst = 1'b1;
            end
            if (cyc == 851) begin
                o = {b4.busy, b4.done, b4.we_a, b4.we_b, b4.addr_a, b4.addr_b, b4.zeta_idx, b4.bf_in_valid, b4.layer};
                checks++;
                if (o !== 31'd0) begin
                    failures++;
                    $display("FAIL abort_reset outputs=%h we=%b busy=%b required all 0", o, b4.we_a, b4.busy);
                end
            end
            if (cyc < 851) @(negedge clk);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_full(1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        b4.start = 1'b0;
        b2.start = 1'b0;
        for (int k = 0; k < 128; k++) zetas[k] = zeta_of(k);
        test_reset();
        do_full(1'b0);
        test_abort();
        do_full(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
